mod10_cmd_arbiter: RTL and testbench

Command controller and two-port round-robin arbiter that sequences the external `count_mod10` up/down decade counter. It accepts LOAD, UP-n, DOWN-n and READ commands from two requesters over valid/ready handshakes, drives the counter's `load`/`mode`/`data_in`, and returns a response with the resulting value. The counter has no enable, so between commands the block holds it by reloading its own output every cycle.

---
 rtl/mod10_cmd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mod10_cmd_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod10_cmd_arbiter.sv
// Two-port round-robin command arbiter sequencing an external count_mod10 decade counter.
// Define MOD10_ARB_FIXED_PRIO_EN to replace round-robin with fixed req0-first priority.
module mod10_cmd_arbiter #(
    parameter int STEP_W = 4  // must be >= 4 so a LOAD argument can carry a full digit
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [STEP_W-1:0] req0_arg,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [STEP_W-1:0] req1_arg,
    output logic              cnt_load,
    output logic              cnt_mode,
    output logic [3:0]        cnt_data_in,
    input  logic [3:0]        cnt_value,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [3:0]        rsp_value,
    output logic              rsp_err,
    output logic              rsp_wrap
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [1:0]        OP_LOAD   = 2'b00;
    localparam logic [1:0]        OP_UP     = 2'b01;
    localparam logic [1:0]        OP_DOWN   = 2'b10;
    localparam logic [STEP_W-1:0] MAX_DIGIT = STEP_W'(9);

    state_t            state;
    logic [1:0]        op_q;
    logic [STEP_W-1:0] arg_q;
    logic [STEP_W-1:0] step_q;
    logic              id_q;
    logic              err_q;
    logic              wrap_q;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [1:0]        sel_op;
    logic [STEP_W-1:0] sel_arg;

`ifdef MOD10_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid && !req0_valid;
`else
    logic prio;  // 0: req0 wins the next tie, 1: req1 wins it

    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid || prio);
`endif

    assign accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
    assign req0_ready = accept && grant0;
    assign req1_ready = accept && grant1;
    assign sel_op     = grant1 ? req1_op  : req0_op;
    assign sel_arg    = grant1 ? req1_arg : req0_arg;

    // The counter has no enable, so every non-EXEC cycle reloads its own value.
    // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_load    = 1'b0;
        cnt_mode    = 1'b0;
        cnt_data_in = 4'd0;
        if (!reset) begin
            if (state == EXEC) begin
                if (op_q == OP_LOAD) begin
                    cnt_load    = 1'b1;
                    cnt_data_in = arg_q[3:0];
                end else begin
                    cnt_mode = (op_q == OP_UP);
                end
            end else begin
                cnt_load    = 1'b1;
                cnt_data_in = cnt_value;
            end
        end
    end

    assign rsp_valid = (state == RESP) && !reset;
    assign rsp_id    = rsp_valid && id_q;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_wrap  = rsp_valid && wrap_q;
    assign rsp_value = rsp_valid ? cnt_value : 4'd0;

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_LOAD;
            arg_q  <= '0;
            step_q <= '0;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
`ifndef MOD10_ARB_FIXED_PRIO_EN
            prio   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        arg_q  <= sel_arg;
                        step_q <= sel_arg;
                        id_q   <= grant1;
                        err_q  <= 1'b0;
                        wrap_q <= 1'b0;
`ifndef MOD10_ARB_FIXED_PRIO_EN
                        if (req0_valid && req1_valid) begin
                            prio <= !prio;
                        end
`endif
                        case (sel_op)
                            OP_LOAD: begin
                                if (sel_arg > MAX_DIGIT) begin
                                    err_q <= 1'b1;
                                    state <= RESP;
                                end else begin
                                    state <= EXEC;
                                end
                            end
                            OP_UP, OP_DOWN: state <= (sel_arg == '0) ? RESP : EXEC;
                            default:        state <= RESP;
                        endcase
                    end
                end
                EXEC: begin
                    if (op_q == OP_LOAD) begin
                        state <= RESP;
                    end else begin
                        // Wrap is judged on the value the counter is about to step from.
                        if ((op_q == OP_UP && cnt_value == 4'd9) ||
                            (op_q == OP_DOWN && cnt_value == 4'd0)) begin
                            wrap_q <= 1'b1;
                        end
                        step_q <= step_q - 1'b1;
                        if (step_q == STEP_W'(1)) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod10_cmd_arbiter.sv
// Self-checking bench for mod10_cmd_arbiter with a behavioural count_mod10 attached.
// Define MOD10_ARB_FIXED_PRIO_EN here too when building the fixed-priority variant.
module tb_mod10_cmd_arbiter;

    localparam int         STEP_W  = 4;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef struct {
        bit              id;
        logic [1:0]      op;
        logic [3:0]      arg;
        logic [3:0]      exp_value;
        bit              exp_err;
        bit              exp_wrap;
        int              exp_lat;
        int              exp_steps;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [1:0]        req0_op, req1_op;
    logic [STEP_W-1:0] req0_arg, req1_arg;
    logic              cnt_load, cnt_mode;
    logic [3:0]        cnt_data_in;
    logic [3:0]        cnt_value;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_err, rsp_wrap;
    logic [3:0]        rsp_value;

    int   passed = 0;
    int   total  = 0;
    vec_t sb[$];

    always #5 clock = ~clock;

    mod10_cmd_arbiter #(.STEP_W(STEP_W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_arg(req0_arg),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_arg(req1_arg),
        .cnt_load(cnt_load), .cnt_mode(cnt_mode), .cnt_data_in(cnt_data_in), .cnt_value(cnt_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_value(rsp_value),
        .rsp_err(rsp_err), .rsp_wrap(rsp_wrap)
    );

    // Reference count_mod10: sync reset, load has priority, mode 1 counts up.
    always @(posedge clock) begin
        if (reset)         cnt_value <= 4'd0;
        else if (cnt_load) cnt_value <= cnt_data_in;
        else if (cnt_mode) cnt_value <= (cnt_value == 4'd9) ? 4'd0 : cnt_value + 4'd1;
        else               cnt_value <= (cnt_value == 4'd0) ? 4'd9 : cnt_value - 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] all_outs();
        return {rsp_valid, rsp_id, rsp_value, rsp_err, rsp_wrap,
                req0_ready, req1_ready, cnt_load, cnt_mode, cnt_data_in};
    endfunction

    task automatic run_cmd(input vec_t v, input int stall);
        int   cyc   = 0;
        int   load0 = 0;
        bit   got   = 0;
        vec_t e;
        rsp_ready = (stall == 0);
        @(posedge clock); #1;
        if (v.id) begin req1_valid = 1; req1_op = v.op; req1_arg = v.arg; end
        else      begin req0_valid = 1; req0_op = v.op; req0_arg = v.arg; end
        @(negedge clock);
        check("ready",       v.id ? req1_ready : req0_ready, 1);
        check("other_ready", v.id ? req0_ready : req1_ready, 0);
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        req0_op = 2'($urandom); req0_arg = 4'($urandom);
        req1_op = 2'($urandom); req1_arg = 4'($urandom);
        sb.push_back(v);
        while (!got && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (rsp_valid) got = 1;
            else if (!cnt_load) load0++;
        end
        check("rsp_seen", got, 1);
        e = sb.pop_front();
        if (!got) return;
        check("latency",   cyc,       e.exp_lat);
        check("rsp_id",    rsp_id,    e.id);
        check("rsp_value", rsp_value, e.exp_value);
        check("rsp_err",   rsp_err,   e.exp_err);
        check("rsp_wrap",  rsp_wrap,  e.exp_wrap);
        check("steps",     load0,     e.exp_steps);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_valid", rsp_valid, 1);
            check("stall_value", rsp_value, e.exp_value);
            check("stall_cnt",   cnt_value, e.exp_value);
        end
        rsp_ready = 1;
        @(posedge clock);
        @(negedge clock);
        check("idle_after", rsp_valid, 0);
        check("hold_value", cnt_value, e.exp_value);
    endtask

    vec_t vec[12];
    int   grants[$];
    int   rsp_idx;
    int   seen;

    initial begin
        vec[0]  = '{0, OP_LOAD, 4'd7,  4'd7, 0, 0, 2,  0};
        vec[1]  = '{0, OP_UP,   4'd5,  4'd2, 0, 1, 6,  5};
        vec[2]  = '{1, OP_DOWN, 4'd2,  4'd0, 0, 0, 3,  2};
        vec[3]  = '{0, OP_DOWN, 4'd1,  4'd9, 0, 1, 2,  1};
        vec[4]  = '{1, OP_LOAD, 4'd12, 4'd9, 1, 0, 1,  0};
        vec[5]  = '{0, OP_READ, 4'd5,  4'd9, 0, 0, 1,  0};
        vec[6]  = '{1, OP_UP,   4'd0,  4'd9, 0, 0, 1,  0};
        vec[7]  = '{0, OP_UP,   4'd1,  4'd0, 0, 1, 2,  1};
        vec[8]  = '{1, OP_LOAD, 4'd9,  4'd9, 0, 0, 2,  0};
        vec[9]  = '{0, OP_DOWN, 4'd15, 4'd4, 0, 1, 16, 15};
        vec[10] = '{1, OP_UP,   4'd15, 4'd9, 0, 1, 16, 15};
        vec[11] = '{0, OP_LOAD, 4'd0,  4'd0, 0, 0, 2,  0};

        // Reset with both requesters asserting: nothing may be granted.
        reset = 1; rsp_ready = 1;
        req0_valid = 1; req0_op = OP_READ; req0_arg = 4'd0;
        req1_valid = 1; req1_op = OP_READ; req1_arg = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outs", all_outs(), 16'd0);
        check("reset_cnt",  cnt_value,  4'd0);
        req0_valid = 0; req1_valid = 0;
        reset = 0;
        #1;
        check("idle_hold_load", cnt_load,    1);
        check("idle_hold_data", cnt_data_in, 4'd0);
        check("idle_no_ready",  {req0_ready, req1_ready}, 2'b00);

        for (int i = 0; i < 12; i++) run_cmd(vec[i], 0);

        // Back-pressured response: UP 3 from 0, consumer stalls 4 cycles.
        run_cmd('{0, OP_UP, 4'd3, 4'd3, 0, 0, 4, 3}, 4);

        // Both requesters continuously valid with READ commands.
        rsp_ready = 1;
        rsp_idx = 0;
        @(posedge clock); #1;
        req0_valid = 1; req0_op = OP_READ; req0_arg = 4'd0;
        req1_valid = 1; req1_op = OP_READ; req1_arg = 4'd0;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            @(negedge clock);
            check("grant_onehot", req0_ready & req1_ready, 0);
            if (rsp_valid && rsp_idx < grants.size()) begin
                check("rr_rsp_id", rsp_id, grants[rsp_idx]);
                rsp_idx++;
            end
            if (req0_ready)      grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
        end
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(negedge clock);
        check("rr_count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) begin
`ifdef MOD10_ARB_FIXED_PRIO_EN
            check("grant_order", grants[k], 0);
`else
            check("grant_order", grants[k], k % 2);
`endif
        end

        // Reset lands in the middle of UP 9; the command must vanish.
        @(posedge clock); #1;
        req0_valid = 1; req0_op = OP_UP; req0_arg = 4'd9;
        @(posedge clock); #1;
        req0_valid = 0;
        repeat (3) @(negedge clock);
        check("mid_exec_counting", cnt_load, 0);
        reset = 1;
        #1;
        check("mid_reset_outs", all_outs(), 16'd0);
        @(posedge clock);
        @(negedge clock);
        check("mid_reset_cnt",   cnt_value,  4'd0);
        check("mid_reset_outs2", all_outs(), 16'd0);
        reset = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("dropped_no_rsp", seen, 0);
        check("after_reset_cnt", cnt_value, 4'd0);
        run_cmd('{1, OP_LOAD, 4'd3, 4'd3, 0, 0, 2, 0}, 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
